ahb_sram_ctrl: RTL and testbench
================================

Name: ahb_sram_ctrl

Overview:
- AHB-Lite slave that sits between the system bus slave port and the 3K x 32 single-port synchronous SRAM macro.
- Drives the SRAM CS/WE/ADDR/Di pins and returns SRAM Do as HRDATA.
- Reads are zero-wait-state. Writes are posted through a one-entry write buffer, with byte-merged read-after-write forwarding.
- Illegal transfers receive a two-cycle AHB ERROR response.

Parameters:
- AW, 12, SRAM word-address width.
- DEPTH, 3072, number of implemented words; word addresses >= DEPTH are out of range.

Ports:
- HCLK  in  1  system clock; SRAM uses the same clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; only [AW+1:0] is decoded.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word.
- HWDATA  in  32  write data (data phase).
- HREADY  in  1  bus-wide ready; an address phase is accepted only when HREADY=1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.
- SRAMRDATA  in  32  SRAM Do; valid the cycle after a CS=1, WE=0 edge.
- SRAMWEN  out  4  per-byte write enables.
- SRAMWDATA  out  32  SRAM Di.
- SRAMCS0  out  1  SRAM enable.
- SRAMADDR  out  AW  SRAM word address.

Behaviour:
- Accept condition: HSEL & HTRANS[1] & HREADY.
- Legality of an accepted transfer:
  - HSIZE <= 2.
  - Naturally aligned: half needs HADDR[0]=0; word needs HADDR[1:0]=0.
  - HADDR[AW+1:2] < DEPTH.
  - Anything else is illegal.
- Byte mask:
  - byte: 1 << HADDR[1:0].
  - half: 4'b0011 << HADDR[1:0].
  - word: 4'b1111.
- Legal read, address phase:
  - Combinationally drive SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR[AW+1:2].
  - Register the read word address for the data phase.
- Read data phase, HREADYOUT=1:
  - HRDATA = SRAMRDATA, with bytes replaced by write-buffer data where wb_valid, wb_addr == read address, and wb_mask[i]=1.
  - Otherwise HRDATA = SRAMRDATA unmodified.
- Legal write, address phase: register address and mask; no SRAM activity from this transfer.
- Write data phase end (HREADYOUT=1 edge): load wb_addr/wb_mask/wb_data <= {addr, mask, HWDATA}; set wb_valid=1.
- Commit:
  - Occurs in any cycle with wb_valid=1 and no legal read address phase being accepted.
  - Drives SRAMCS0=1, SRAMWEN=wb_mask, SRAMADDR=wb_addr, SRAMWDATA=wb_data.
  - wb_valid clears at that edge unless a new write loads the buffer at the same edge; the load wins.
- Buffer conflict:
  - Condition: a write data phase with wb_valid=1 where the buffer cannot commit this cycle (concurrent read address phase).
  - Response: insert exactly one wait state (HREADYOUT=0).
  - During the wait, HREADY=0 blocks address phases, so the old entry commits; then HREADYOUT=1 and the new write loads.
- Illegal transfer, two data-phase cycles:
  - Cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
  - No SRAM write and no buffer load. The buffer may commit during these cycles.
- IDLE/BUSY transfers or HSEL=0: OKAY, zero wait states, no SRAM access other than commits.
- SRAMWDATA = wb_data at all times.
- SRAMCS0=0 and SRAMWEN=0 whenever there is neither a read nor a commit.
- Reset values: HREADYOUT=1, HRESP=0, wb_valid=0, wb_addr/wb_mask/wb_data=0, all data-phase state cleared, SRAMCS0=0, SRAMWEN=0.
- Reset mid-operation: an uncommitted buffered write is discarded; a transfer in progress is abandoned.
- HRDATA is don't-care outside read data phases; hold it at SRAMRDATA.

Test Plan:
1. Word write 0xDEADBEEF to 0x0000_0010, then IDLE -> commit on the next cycle: SRAMCS0=1, SRAMWEN=4'hF, SRAMADDR=4, SRAMWDATA=0xDEADBEEF. No wait states.
2. Byte write 0xA5 to 0x0000_0013, immediately followed by a word read of 0x0000_0010 (SRAM word holds 0x11223344) -> HRDATA=0xA5223344, zero waits. Commit happens in the following idle cycle.
3. Write, write, read back-to-back -> exactly one HREADYOUT=0 cycle in the second write's data phase. The first write commits in that cycle, and the read returns merged data.
4. Word read at 0x0000_3000 (word 3072) -> HREADYOUT 0 then 1, with HRESP=1 both cycles; no SRAMCS0 for this transfer. Half write at 0x0000_0001 -> same ERROR pattern, and the buffer is unchanged.
5. Assert HRESETn=0 while wb_valid=1 -> HREADYOUT=1, HRESP=0, SRAMCS0=0 immediately. After release, the discarded write never appears on the SRAM pins.
6. 1000 random legal reads/writes/sizes with idles, checked against a byte-array model -> every read matches, and no ERROR responses occur.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave for a single-port synchronous SRAM: zero-wait reads, writes posted through a
// one-entry byte-masked buffer that forwards into reads of the same word.
module ahb_sram_ctrl #(
   parameter int unsigned AW    = 12,
   parameter int unsigned DEPTH = 3072
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   input  logic [2:0]    HSIZE,
   input  logic [31:0]   HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic          HRESP,
   output logic [31:0]   HRDATA,
   input  logic [31:0]   SRAMRDATA,
   output logic [3:0]    SRAMWEN,
   output logic [31:0]   SRAMWDATA,
   output logic          SRAMCS0,
   output logic [AW-1:0] SRAMADDR
);

   typedef enum logic [2:0] {StIdle, StRead, StWrite, StErr1, StErr2} state_e;

   localparam logic [AW:0] DepthLim = DEPTH[AW:0];

   state_e        state_q, state_d;
   logic [AW-1:0] dp_addr_q, dp_addr_d;
   logic [3:0]    dp_mask_q, dp_mask_d;
   logic          wb_valid_q, wb_valid_d;
   logic [AW-1:0] wb_addr_q, wb_addr_d;
   logic [3:0]    wb_mask_q, wb_mask_d;
   logic [31:0]   wb_data_q, wb_data_d;

   logic [AW-1:0] haddr_word;
   logic [3:0]    hmask;
   logic          align_ok, range_ok, legal;
   logic          acc, rd_acc, wr_acc, ill_acc, rd_req;
   logic          stall, commit, wb_load;
   logic          unused_bits;

   assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

   assign haddr_word = HADDR[AW+1:2];
   assign range_ok   = {1'b0, haddr_word} < DepthLim;

   always_comb begin
      align_ok = 1'b0;
      hmask    = 4'b0000;
      case (HSIZE)
         3'd0: begin
            align_ok = 1'b1;
            hmask    = 4'b0001 << HADDR[1:0];
         end
         3'd1: begin
            align_ok = ~HADDR[0];
            hmask    = 4'b0011 << HADDR[1:0];
         end
         3'd2: begin
            align_ok = (HADDR[1:0] == 2'b00);
            hmask    = 4'b1111;
         end
         default: ;
      endcase
   end

   assign legal   = align_ok & range_ok;
   assign acc     = HSEL & HTRANS[1] & HREADY;
   assign rd_acc  = acc & legal & ~HWRITE;
   assign wr_acc  = acc & legal & HWRITE;
   assign ill_acc = acc & ~legal;

   // Read request without HREADY: HREADY echoes our own HREADYOUT during our data phase,
   // so using it here would close a combinational loop.
   assign rd_req  = HSEL & HTRANS[1] & legal & ~HWRITE;
   assign stall   = (state_q == StWrite) & wb_valid_q & rd_req;
   assign commit  = wb_valid_q & ~rd_acc;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         dp_addr_q  <= '0;
         dp_mask_q  <= '0;
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_mask_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         dp_addr_q  <= dp_addr_d;
         dp_mask_q  <= dp_mask_d;
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_mask_q  <= wb_mask_d;
         wb_data_q  <= wb_data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == StErr1) begin
         state_d = StErr2;
      end else if (HREADYOUT) begin
         if (rd_acc) begin
            state_d = StRead;
         end else if (wr_acc) begin
            state_d = StWrite;
         end else if (ill_acc) begin
            state_d = StErr1;
         end else begin
            state_d = StIdle;
         end
      end
   end

   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      wb_load   = 1'b0;
      case (state_q)
         StWrite: begin
            HREADYOUT = ~stall;
            wb_load   = ~stall;
         end
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
         end
         StErr2:  HRESP = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      dp_addr_d  = dp_addr_q;
      dp_mask_d  = dp_mask_q;
      wb_valid_d = wb_valid_q;
      wb_addr_d  = wb_addr_q;
      wb_mask_d  = wb_mask_q;
      wb_data_d  = wb_data_q;
      if (acc & legal) begin
         dp_addr_d = haddr_word;
         dp_mask_d = hmask;
      end
      if (commit) begin
         wb_valid_d = 1'b0;
      end
      // A load in the same cycle as a commit replaces the departing entry.
      if (wb_load) begin
         wb_valid_d = 1'b1;
         wb_addr_d  = dp_addr_q;
         wb_mask_d  = dp_mask_q;
         wb_data_d  = HWDATA;
      end
   end

   always_comb begin
      HRDATA = SRAMRDATA;
      if ((state_q == StRead) && wb_valid_q && (wb_addr_q == dp_addr_q)) begin
         for (int i = 0; i < 4; i++) begin
            if (wb_mask_q[i]) begin
               HRDATA[8*i +: 8] = wb_data_q[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      SRAMCS0  = 1'b0;
      SRAMWEN  = 4'b0000;
      SRAMADDR = '0;
      if (rd_acc) begin
         SRAMCS0  = 1'b1;
         SRAMADDR = haddr_word;
      end else if (wb_valid_q) begin
         SRAMCS0  = 1'b1;
         SRAMWEN  = wb_mask_q;
         SRAMADDR = wb_addr_q;
      end
   end

   assign SRAMWDATA = wb_data_q;

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: behavioural SRAM macro, pipelined AHB master tasks, and a
// byte-array reference feeding a queue of expected read data.
module tb_ahb_sram_ctrl;

   localparam int unsigned AW    = 12;
   localparam int unsigned DEPTH = 3072;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b1;
   logic          HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAMCS0;
   logic [31:0]   HADDR, HWDATA, HRDATA, SRAMWDATA;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [3:0]    SRAMWEN;
   logic [AW-1:0] SRAMADDR;
   logic [31:0]   sram_rdata;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb_sram_ctrl #(.AW(AW), .DEPTH(DEPTH)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .SRAMRDATA (sram_rdata),
      .SRAMWEN   (SRAMWEN),
      .SRAMWDATA (SRAMWDATA),
      .SRAMCS0   (SRAMCS0),
      .SRAMADDR  (SRAMADDR)
   );

   function automatic logic [31:0] init_word(input int w);
      return 32'h5A5A_0000 | 32'(w);
   endfunction

   // SRAM macro model
   logic [31:0] sram [DEPTH];
   initial begin
      logic [31:0] merged;
      sram_rdata = 32'h0;
      for (int i = 0; i < int'(DEPTH); i++) sram[i] = init_word(i);
      forever begin
         @(posedge HCLK);
         if (SRAMCS0 && (32'(SRAMADDR) < DEPTH)) begin
            if (SRAMWEN == 4'h0) begin
               sram_rdata <= sram[SRAMADDR];
            end else begin
               merged = sram[SRAMADDR];
               for (int i = 0; i < 4; i++)
                  if (SRAMWEN[i]) merged[8*i +: 8] = SRAMWDATA[8*i +: 8];
               sram[SRAMADDR] <= merged;
            end
         end
      end
   end

   int   ghost_writes = 0;
   logic watch = 1'b0;
   always @(negedge HCLK)
      if (watch && SRAMCS0 && (SRAMWEN != 4'h0) && (SRAMADDR == 12'd16)) ghost_writes++;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic finish_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Reference memory and scoreboard
   logic [7:0] ref_mem [DEPTH*4];
   typedef struct packed {
      logic [31:0] data;
      logic [31:0] mask;
   } exp_t;
   exp_t exp_q[$];

   function automatic logic is_legal(input logic [2:0] size, input logic [31:0] addr);
      logic ok;
      case (size)
         3'd0:    ok = 1'b1;
         3'd1:    ok = (addr[0] == 1'b0);
         3'd2:    ok = (addr[1:0] == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok && (32'(addr[AW+1:2]) < DEPTH);
   endfunction

   function automatic logic [31:0] lane_mask(input logic [2:0] size, input logic [31:0] addr);
      int sh = 8 * int'(addr[1:0]);
      case (size)
         3'd0:    return 32'h0000_00FF << sh;
         3'd1:    return 32'h0000_FFFF << sh;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

   function automatic logic [31:0] ref_word(input int w);
      return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
   endfunction

   task automatic ref_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
      logic [31:0] m;
      int w;
      m = lane_mask(size, addr);
      w = int'(addr[AW+1:2]);
      for (int i = 0; i < 4; i++)
         if (m[8*i]) ref_mem[4*w+i] = data[8*i +: 8];
   endtask

   // Pending data phase and per-call observations
   logic          p_valid = 1'b0, p_write = 1'b0, p_legal = 1'b0;
   logic [31:0]   p_wdata = 32'h0;
   int            last_waits;
   logic          last_resp, last_cs, w_seen, w_cs, w_resp;
   logic [3:0]    last_wen, w_wen;
   logic [AW-1:0] last_addr, w_addr;
   logic [31:0]   last_wdata, last_rdata, w_wdata;

   // Presents one address phase (and the previous transfer's data) and returns once it is taken.
   task automatic issue(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      int   waits;
      exp_t e;
      waits  = 0;
      HSEL   = sel;
      HTRANS = trans;
      HWRITE = wr;
      HSIZE  = size;
      HADDR  = addr;
      HWDATA = p_write ? p_wdata : 32'h0;
      w_seen = 1'b0;
      forever begin
         @(negedge HCLK);
         if (HREADYOUT) break;
         if (!w_seen) begin
            w_seen  = 1'b1;
            w_cs    = SRAMCS0;
            w_wen   = SRAMWEN;
            w_addr  = SRAMADDR;
            w_wdata = SRAMWDATA;
            w_resp  = HRESP;
         end
         waits++;
         if (waits > 4) begin
            check_val("ready_timeout", 32'(waits), 32'd4);
            finish_run();
         end
         @(posedge HCLK);
         #1;
      end
      last_waits = waits;
      last_resp  = HRESP;
      last_cs    = SRAMCS0;
      last_wen   = SRAMWEN;
      last_addr  = SRAMADDR;
      last_wdata = SRAMWDATA;
      last_rdata = HRDATA;
      if (p_valid && !p_legal) begin
         check_val("err_waits", 32'(waits), 32'd1);
         check_val("err_resp_c2", 32'(HRESP), 32'd1);
         if (w_seen) check_val("err_resp_c1", 32'(w_resp), 32'd1);
      end else if (p_valid) begin
         check_val("okay_resp", 32'(HRESP), 32'd0);
         if (p_write) begin
            check_val("write_waits_le1", 32'(waits <= 1), 32'd1);
         end else begin
            check_val("read_waits", 32'(waits), 32'd0);
            if (exp_q.size() == 0) begin
               check_val("sb_underflow", 32'd0, 32'd1);
            end else begin
               e = exp_q.pop_front();
               check_val("rdata", HRDATA & e.mask, e.data & e.mask);
            end
         end
      end else begin
         check_val("idle_resp", {30'd0, HRESP, 1'b0} | 32'(waits), 32'd0);
      end
      @(posedge HCLK);
      #1;
      p_valid = sel && trans[1];
      p_write = wr;
      p_legal = is_legal(size, addr);
      p_wdata = wdata;
      if (p_valid && p_legal) begin
         if (wr) begin
            ref_write(addr, size, wdata);
         end else begin
            e.data = ref_word(int'(addr[AW+1:2]));
            e.mask = lane_mask(size, addr);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic idle();
      issue(1'b1, 2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      check_val("global_timeout", 32'd1, 32'd0);
      finish_run();
   end

   initial begin
      logic [31:0] saved, a, d;
      int          kind, w;
      logic [2:0]  sz;

      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'h0; HWDATA = 32'h0;
      for (int i = 0; i < int'(DEPTH); i++)
         for (int j = 0; j < 4; j++) ref_mem[4*i+j] = init_word(i)[8*j +: 8];

      #2 HRESETn = 1'b0;
      #1;
      check_val("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      check_val("rst_hresp", 32'(HRESP), 32'd0);
      check_val("rst_cs", 32'(SRAMCS0), 32'd0);
      check_val("rst_wen", 32'(SRAMWEN), 32'd0);
      @(posedge HCLK);
      @(posedge HCLK);
      #1 HRESETn = 1'b1;

      // 1: posted word write, commit in the following idle cycle
      issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF);
      idle();
      check_val("t1_waits", 32'(last_waits), 32'd0);
      check_val("t1_no_early_cs", 32'(last_cs), 32'd0);
      idle();
      check_val("t1_cs", 32'(last_cs), 32'd1);
      check_val("t1_wen", 32'(last_wen), 32'hF);
      check_val("t1_addr", 32'(last_addr), 32'd4);
      check_val("t1_wdata", last_wdata, 32'hDEAD_BEEF);

      // 2: byte write then read of the same word forwards the byte
      issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0010, 32'h1122_3344);
      idle();
      idle();
      issue(1'b1, 2'b10, 1'b1, 3'd0, 32'h0000_0013, 32'hA5A5_A5A5);
      issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0010, 32'h0);
      check_val("t2_wr_waits", 32'(last_waits), 32'd0);
      idle();
      check_val("t2_rdata", last_rdata, 32'hA522_3344);
      check_val("t2_rd_waits", 32'(last_waits), 32'd0);
      check_val("t2_commit_cs", 32'(last_cs), 32'd1);
      check_val("t2_commit_wen", 32'(last_wen), 32'h8);
      check_val("t2_commit_addr", 32'(last_addr), 32'd4);

      // 3: write, write, read -> one wait state while the first write commits
      issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0020, 32'h0102_0304);
      issue(1'b1, 2'b11, 1'b1, 3'd1, 32'h0000_0026, 32'hBEEF_0000);
      check_val("t3_w1_waits", 32'(last_waits), 32'd0);
      issue(1'b1, 2'b11, 1'b0, 3'd2, 32'h0000_0024, 32'h0);
      check_val("t3_w2_waits", 32'(last_waits), 32'd1);
      check_val("t3_stall_cs", 32'(w_cs), 32'd1);
      check_val("t3_stall_wen", 32'(w_wen), 32'hF);
      check_val("t3_stall_addr", 32'(w_addr), 32'd8);
      check_val("t3_stall_wdata", w_wdata, 32'h0102_0304);
      idle();
      check_val("t3_rdata", last_rdata, 32'hBEEF_0009);

      // 4: out-of-range read and misaligned half write both take ERROR
      idle();
      issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_3000, 32'h0);
      check_val("t4_rd_addr_cs", 32'(last_cs), 32'd0);
      idle();
      check_val("t4_rd_err_c1_cs", 32'(w_cs), 32'd0);
      check_val("t4_rd_err_c2_cs", 32'(last_cs), 32'd0);
      issue(1'b1, 2'b10, 1'b1, 3'd1, 32'h0000_0001, 32'h1234_5678);
      idle();
      check_val("t4_wr_err_c1_cs", 32'(w_cs), 32'd0);
      check_val("t4_wr_err_c2_cs", 32'(last_cs), 32'd0);
      idle();
      check_val("t4_no_load_cs", 32'(last_cs), 32'd0);
      issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0000, 32'h0);
      idle();

      // 5: reset while the buffer holds an uncommitted write
      saved = ref_word(16);
      issue(1'b1, 2'b10, 1'b1, 3'd2, 32'h0000_0040, 32'hCAFE_F00D);
      idle();
      watch = 1'b1;
      HRESETn = 1'b0;
      #1;
      check_val("t5_hreadyout", 32'(HREADYOUT), 32'd1);
      check_val("t5_hresp", 32'(HRESP), 32'd0);
      check_val("t5_cs", 32'(SRAMCS0), 32'd0);
      ref_write(32'h0000_0040, 3'd2, saved);
      exp_q.delete();
      p_valid = 1'b0;
      p_write = 1'b0;
      @(posedge HCLK);
      @(posedge HCLK);
      #1 HRESETn = 1'b1;
      idle();
      idle();
      issue(1'b1, 2'b10, 1'b0, 3'd2, 32'h0000_0040, 32'h0);
      idle();
      check_val("t5_old_data", last_rdata, 32'h5A5A_0010);
      idle();
      check_val("t5_ghost_writes", 32'(ghost_writes), 32'd0);
      watch = 1'b0;

      // 6: random legal traffic against the reference
      for (int n = 0; n < 1000; n++) begin
         kind = $urandom_range(0, 9);
         w    = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
         sz   = 3'($urandom_range(0, 2));
         a    = 32'(w) << 2;
         if (sz == 3'd0) a[1:0] = 2'($urandom_range(0, 3));
         else if (sz == 3'd1) a[1] = 1'($urandom_range(0, 1));
         d = $urandom;
         case (kind)
            0:       issue(1'b1, 2'b00, 1'b1, sz, a, d);
            1:       issue(1'b1, 2'b01, 1'b0, sz, a, d);
            2:       issue(1'b0, 2'b10, 1'b1, sz, a, d);
            3, 4, 5: issue(1'b1, {1'b1, 1'($urandom_range(0, 1))}, 1'b0, sz, a, d);
            default: issue(1'b1, {1'b1, 1'($urandom_range(0, 1))}, 1'b1, sz, a, d);
         endcase
      end
      idle();
      idle();
      check_val("sb_drained", 32'(exp_q.size()), 32'd0);
      finish_run();
   end

endmodule
